side_road_sensor: RTL and testbench

Upstream conditioning stage for the highway/side-road traffic controller. Takes the raw side-road vehicle loop detector, synchronises and debounces it, and keeps a saturating count of waiting vehicles. Vehicles drain from the count while the controller shows side-road green. Drives the controller's `x` input (car waiting on side road) and takes the controller's side-road light code `sw` back as feedback.

---
 rtl/side_road_sensor.sv | 112 +++++++++++
 tb/tb_side_road_sensor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/side_road_sensor.sv
// Side-road loop detector conditioning: sync, debounce, waiting-vehicle count.
// Arrivals come from debounced rising commits; departures are paced by side-road green.
module side_road_sensor #(
  parameter int DEBOUNCE      = 4,
  parameter int DEPART_CYCLES = 3,
  parameter int QW            = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          raw_sensor,
  input  logic [1:0]    sw,
  output logic          x,
  output logic [QW-1:0] queue_count,
  output logic          overflow
);

  localparam int DBW = $clog2(DEBOUNCE);
  localparam int DTW =
    (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [DTW-1:0] DT_LAST = DTW'(DEPART_CYCLES - 1);
  localparam logic [QW-1:0]  Q_MAX   = '1;
  localparam logic [1:0]     SW_GREEN = 2'd2;

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           det_q, det_d;
  logic [DBW-1:0] dbc_q, dbc_d;
  logic [DTW-1:0] dt_q, dt_d;
  logic [QW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           x_q, x_d;

  logic arrival;
  logic depart;
  logic green;

  always_comb begin
    s1_d    = raw_sensor;
    s2_d    = s1_q;
    det_d   = det_q;
    dbc_d   = '0;
    arrival = 1'b0;
    if (s2_q != det_q) begin
      if (dbc_q == DB_LAST) begin
        det_d   = s2_q;
        arrival = s2_q;
      end else begin
        dbc_d = dbc_q + DBW'(1);
      end
    end
  end

  // Partial green progress is dropped whenever green lapses or queue empties.
  always_comb begin
    green  = (sw == SW_GREEN) && (cnt_q != '0);
    depart = 1'b0;
    dt_d   = '0;
    if (green) begin
      if (dt_q == DT_LAST) begin
        depart = 1'b1;
      end else begin
        dt_d = dt_q + DTW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (1'b1)
      (arrival && !depart): begin
        if (cnt_q == Q_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + QW'(1);
        end
      end
      (depart && !arrival): cnt_d = cnt_q - QW'(1);
      default: ;
    endcase
    x_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      det_q <= 1'b0;
      dbc_q <= '0;
      dt_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      x_q   <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      det_q <= det_d;
      dbc_q <= dbc_d;
      dt_q  <= dt_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      x_q   <= x_d;
    end
  end

  assign x           = x_q;
  assign queue_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_side_road_sensor.sv
// Scoreboard bench for side_road_sensor: default build plus a QW=2 build.
// Driver pushes model predictions; a negedge monitor pops and compares.
module tb_side_road_sensor;

  localparam int DEB = 4;
  localparam int DEP = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       raw = 1'b0;
  logic [1:0] sw  = 2'd0;

  logic       x1, ovf1;
  logic [3:0] q1;
  logic       x2, ovf2;
  logic [1:0] q2;

  always #5 clk = ~clk;

  side_road_sensor #(.DEBOUNCE(DEB), .DEPART_CYCLES(DEP), .QW(4)) dut (
    .clk(clk), .clr(clr), .raw_sensor(raw), .sw(sw),
    .x(x1), .queue_count(q1), .overflow(ovf1)
  );

  side_road_sensor #(.DEBOUNCE(DEB), .DEPART_CYCLES(DEP), .QW(2)) dut2 (
    .clk(clk), .clr(clr), .raw_sensor(raw), .sw(sw),
    .x(x2), .queue_count(q2), .overflow(ovf2)
  );

  typedef struct {
    int cnt[2];
    bit ovf[2];
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int passed = 0;

  // Reference model: vehicles as plain integers, debounce as run length.
  bit sync_pipe[$] = '{0, 0};
  bit det_lvl = 0;
  int run_len = 0;
  int cnt[2] = '{0, 0};
  int green_run[2] = '{0, 0};
  bit ovf[2] = '{0, 0};
  int maxv[2] = '{15, 3};

  task automatic model(input bit r, input int s, input bit c);
    bit s2;
    bit arr;
    bit dep;
    if (c) begin
      sync_pipe = '{0, 0};
      det_lvl = 0;
      run_len = 0;
      for (int m = 0; m < 2; m++) begin
        cnt[m] = 0;
        green_run[m] = 0;
        ovf[m] = 0;
      end
      return;
    end
    s2 = sync_pipe[0];
    sync_pipe.push_back(r);
    void'(sync_pipe.pop_front());
    arr = 0;
    if (s2 != det_lvl) begin
      run_len++;
      if (run_len == DEB) begin
        det_lvl = s2;
        run_len = 0;
        arr = s2;
      end
    end else begin
      run_len = 0;
    end
    for (int m = 0; m < 2; m++) begin
      dep = 0;
      if (s == 2 && cnt[m] > 0) begin
        green_run[m]++;
        if (green_run[m] == DEP) begin
          dep = 1;
          green_run[m] = 0;
        end
      end else begin
        green_run[m] = 0;
      end
      if (arr && !dep) begin
        if (cnt[m] == maxv[m]) ovf[m] = 1;
        else cnt[m]++;
      end else if (dep && !arr) begin
        cnt[m]--;
      end
    end
  endtask

  task automatic step(input bit r, input int s, input bit c);
    exp_t e;
    raw = r;
    sw  = 2'(s);
    clr = c;
    @(posedge clk);
    model(r, s, c);
    e.cnt = cnt;
    e.ovf = ovf;
    sbq.push_back(e);
    #1;
  endtask

  task automatic hold(input bit r, input int s, input int n);
    for (int i = 0; i < n; i++) step(r, s, 1'b0);
  endtask

  task automatic pulse(input int hi, input int lo, input int s);
    hold(1'b1, s, hi);
    hold(1'b0, s, lo);
  endtask

  function automatic void cmp(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d",
                  nm, $time, act, exp);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("q_count", int'(q1), e.cnt[0]);
      cmp("x", int'(x1), int'(e.cnt[0] != 0));
      cmp("overflow", int'(ovf1), int'(e.ovf[0]));
      cmp("q_count_qw2", int'(q2), e.cnt[1]);
      cmp("x_qw2", int'(x2), int'(e.cnt[1] != 0));
      cmp("overflow_qw2", int'(ovf2), int'(e.ovf[1]));
    end
  end

  // Green starts 3 edges after raw rises: commit and departure share an edge.
  task automatic aligned_pair();
    hold(1'b1, 0, 3);
    hold(1'b1, 2, 3);
    hold(1'b0, 0, 8);
  endtask

  initial begin
    // reset held with sensor high, then released
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1);
    hold(1'b1, 0, 8);
    hold(1'b0, 0, 8);
    step(1'b0, 0, 1'b1);
    // glitches: 3-cycle pulse, then 8-cycle pulse with a 1-cycle dropout
    pulse(3, 8, 0);
    hold(1'b1, 0, 4);
    hold(1'b0, 0, 1);
    hold(1'b1, 0, 3);
    hold(1'b0, 0, 8);
    step(1'b0, 0, 1'b1);
    // queue three, then drain on 9 green cycles
    for (int i = 0; i < 3; i++) pulse(6, 6, 0);
    hold(1'b0, 0, 4);
    hold(1'b0, 2, 9);
    hold(1'b0, 0, 3);
    // interrupted green at count 2, amber break, code 3 never drains
    for (int i = 0; i < 2; i++) pulse(6, 6, 0);
    hold(1'b0, 0, 4);
    hold(1'b0, 2, 2);
    hold(1'b0, 1, 1);
    hold(1'b0, 3, 6);
    hold(1'b0, 2, 4);
    // simultaneous arrival/departure at count 2 (QW=4 and QW=2)
    pulse(6, 6, 0);
    hold(1'b0, 0, 4);
    aligned_pair();
    // fill to 3 (max of QW=2), align again: no overflow on either build
    pulse(6, 6, 0);
    aligned_pair();
    // saturate QW=2, then one departure, then clear
    for (int i = 0; i < 3; i++) pulse(6, 6, 0);
    hold(1'b0, 2, 3);
    hold(1'b0, 0, 4);
    step(1'b0, 0, 1'b1);
    // saturate QW=4 with 17 arrivals
    for (int i = 0; i < 17; i++) pulse(6, 6, 0);
    hold(1'b0, 2, 7);
    step(1'b0, 0, 1'b1);
    // randomized phase: bouncy sensor, random light codes, rare clears
    begin
      int rh = 0;
      int sh = 0;
      bit r = 0;
      int s = 0;
      for (int i = 0; i < 4000; i++) begin
        if (rh == 0) begin
          r  = ~r;
          rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                           : $urandom_range(4, 12);
        end
        if (sh == 0) begin
          s  = ($urandom_range(0, 1) == 0) ? 2 : $urandom_range(0, 3);
          sh = $urandom_range(1, 20);
        end
        rh--;
        sh--;
        step(r, s, $urandom_range(0, 399) == 0);
      end
    end
    begin
      int budget = 20;
      while (sbq.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (sbq.size() > 0) begin
        checks++;
        $display("FAIL drain: got %0d entries expected 0", sbq.size());
      end
    end
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
